arb_mux_n: RTL

Parametrised N-input registered arbitrating multiplexer for the pipeline datapath, generalising the fixed 2:1/3:1 select muxes. Up to N producers present data words with valid/ready handshakes. The block grants one producer per cycle by fixed priority or round-robin and captures its word into a single output register. It sits between multiple requesters and one shared consumer, such as a write-back or memory-request port.

---
 rtl/arb_mux_n.sv | 74 +++++++
 1 files changed

// File: rtl/arb_mux_n.sv
// N-input registered arbitrating multiplexer: grants one valid producer per cycle
// (fixed priority or round-robin) and captures its word into a single output register.
module arb_mux_n #(
    parameter int LEN   = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [N-1:0]     in_valid,
    input  logic [N*LEN-1:0] in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [LEN-1:0]   out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);

    // Handshake: a word moves on any edge where valid & ready are both high on that
    // side; valid never waits for ready, and in_ready is a one-hot (or zero) grant.
    logic             can_load;
    logic             grant_any;
    logic             take;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr;
    logic [LEN-1:0]   grant_data;

    assign can_load = !out_valid || out_ready;

    // Round-robin scans from the slot after the last winner; fixed priority from 0.
    always_comb begin
        int j;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            j = k;
            if (MODE == 1) j = (int'(ptr) + 1 + k) % N;
            if (!grant_any && in_valid[j]) begin
                grant_any  = 1'b1;
                grant_idx  = SEL_W'(j);
                grant_data = in_data[j*LEN +: LEN];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && !flush && can_load && grant_any) in_ready[grant_idx] = 1'b1;
    end

    assign take = |in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SEL_W'(N - 1);
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant_idx;
            ptr       <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
